mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN, default 32, data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  CPU access request.
REQ-006 in_ready  out  1  unit can accept a request.
REQ-007 in_wen  in  1  1 = store, 0 = load.
REQ-008 in_op  in  3  access type: 0 b, 1 h, 2 w, 3 d, 4 bu, 5 hu, 6 wu; stores use only the size (0-3).
REQ-009 in_addr  in  ADDR_W  byte address.
REQ-010 in_wdata  in  XLEN  store data, right-aligned.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 out_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-014 out_err  out  1  misaligned access or illegal op.
REQ-015 bus_req_valid  out  1  bus request.
REQ-016 bus_req_ready  in  1  bus accepts the request.
REQ-017 bus_req_wen  out  1  bus write.
REQ-018 bus_req_addr  out  ADDR_W  in_addr with the low log2(XLEN/8) bits cleared.
REQ-019 bus_req_wdata  out  XLEN  lane-shifted store data.
REQ-020 bus_req_wstrb  out  XLEN/8  byte-enable mask.
REQ-021 bus_resp_valid  in  1  bus response, reads and writes; one-cycle pulse.
REQ-022 bus_resp_rdata  in  XLEN  full-word read data.

Function
REQ-023 The FSM SHALL have four states: IDLE, REQ, RESP and DONE.
REQ-024 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-025 In IDLE, when in_valid is 1, the unit SHALL latch op, wen, addr and wdata and move to REQ, or to DONE with the error flag set if REQ-026 applies.
REQ-026 An access is an error when addr is not a multiple of the access size, when in_op is 7, or when XLEN=32 and the size is d or the op is wu; an error SHALL issue no bus request.
REQ-027 In REQ, bus_req_valid SHALL be 1 and all bus_req_* signals SHALL stay stable until bus_req_ready is 1; the unit SHALL then move to RESP.
REQ-028 In RESP, the unit SHALL wait for bus_resp_valid, capture the result, then move to DONE.
REQ-029 bus_resp_valid SHALL be ignored outside RESP.
REQ-030 In DONE, out_valid SHALL be 1 and out_rdata and out_err SHALL be held until out_ready is 1; the unit SHALL then move to IDLE.
REQ-031 Minimum latency SHALL be: accept at cycle 0, bus_req_valid at cycle 1, response at cycle 2, out_valid at cycle 3; an error SHALL give out_valid at cycle 1.
REQ-032 The lane SHALL be addr[log2(XLEN/8)-1:0].
REQ-033 Load data SHALL be bus_resp_rdata shifted right by lane*8, truncated to the size, then sign-extended (ops 0-3) or zero-extended (ops 4-6) to XLEN.
REQ-034 Store wdata SHALL be the low size bytes of in_wdata shifted left by lane*8, with unused bytes 0.
REQ-035 Store wstrb SHALL be ((1<<bytes)-1)<<lane; load wstrb SHALL be 0.
REQ-036 Only one transaction SHALL be outstanding; a new request SHALL be accepted no earlier than the cycle after the DONE handshake.

Reset
REQ-037 When rst is 1, the state SHALL become IDLE and out_valid, bus_req_valid, out_err and out_rdata SHALL be 0 on the next edge.
REQ-038 When rst is 1, in_ready SHALL be 0 during that cycle.
REQ-039 Reset in any state SHALL abandon the transaction; no out_valid for it SHALL follow, and a bus response still in flight SHALL be ignored.

Verification
REQ-040 With XLEN=32, lb at 0x80000003 and bus_resp_rdata 0x80112233 SHALL give bus_req_addr 0x80000000 and out_rdata 0xFFFFFF80 with out_err 0.
REQ-041 lhu at 0x80000002 with rdata 0xBEEF1234 SHALL give out_rdata 0x0000BEEF; lh at the same address SHALL give 0xFFFFBEEF.
REQ-042 sh at 0x80000002 with wdata 0x1234ABCD SHALL give bus_req_wdata 0xABCD0000, wstrb 4'b1100 and out_rdata 0.
REQ-043 lw at 0x80000001 SHALL give out_err 1 with out_valid at cycle 1 and bus_req_valid never 1; ld at XLEN=32 SHALL behave the same.
REQ-044 With bus_req_ready low for 3 cycles, bus_req_* SHALL stay stable; with out_ready low for 2 cycles, out_valid and out_rdata SHALL hold; in_ready SHALL stay 0 throughout.
REQ-045 With XLEN=64, lwu at 0x80000004 and rdata 0xF0000000_00000000 SHALL give out_rdata 0x00000000_F0000000; rst asserted in RESP SHALL give IDLE with no out_valid, even if bus_resp_valid arrives next cycle.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between a CPU request port and a word-wide bus.
// One transaction is in flight at a time (IDLE -> REQ -> RESP -> DONE).
// Misaligned accesses and illegal ops finish directly in DONE with out_err
// set and never touch the bus.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        CPU request handshake
//   in_wen, in_op            1 = store; op 0 b,1 h,2 w,3 d,4 bu,5 hu,6 wu
//   in_addr, in_wdata        byte address, right-aligned store data
//   out_valid/out_ready      result handshake
//   out_rdata, out_err       extended load data (0 for stores/errors), error
//   bus_req_*                word-aligned bus request with lane-shifted data
//   bus_resp_valid/rdata     one-cycle bus response with full-word read data
module mem_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_wen,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [XLEN-1:0]   bus_req_wdata,
  output logic [XLEN/8-1:0] bus_req_wstrb,
  input  logic              bus_resp_valid,
  input  logic [XLEN-1:0]   bus_resp_rdata
);
  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic                wen_q, wen_d;
  logic [2:0]          op_q, op_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [NB-1:0]       wstrb_q, wstrb_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;

  // Request decode
  logic [1:0]          in_size;
  logic [LANE_W-1:0]   in_lane;
  logic                in_misalign;
  logic                in_err;
  logic [XLEN-1:0]     data_mask;
  logic [NB-1:0]       strb_low;
  logic [XLEN-1:0]     st_data;
  logic [NB-1:0]       st_strb;

  assign in_size = in_op[1:0];
  assign in_lane = in_addr[LANE_W-1:0];

  always_comb begin
    in_misalign = 1'b0;
    case (in_size)
      2'd0:    in_misalign = 1'b0;
      2'd1:    in_misalign = in_addr[0];
      2'd2:    in_misalign = |in_addr[1:0];
      default: in_misalign = |in_addr[2:0];
    endcase
  end

  // Doublewords and wu only exist on a 64-bit datapath.
  assign in_err = (in_op == 3'd7) || in_misalign ||
                  ((XLEN == 32) && ((in_size == 2'd3) || (in_op == 3'd6)));

  always_comb begin
    data_mask = '0;
    strb_low  = '0;
    for (int i = 0; i < XLEN; i++) data_mask[i] = (i < (8 << in_size));
    for (int i = 0; i < NB; i++)   strb_low[i]  = (i < (1 << in_size));
  end

  assign st_data = (in_wdata & data_mask) << {in_lane, 3'b000};
  assign st_strb = strb_low << in_lane;

  // Load extraction: shift the addressed lane down, then fill everything
  // above the access size with the sign bit (signed ops) or zero.
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_ext;
  logic            ld_msb;

  assign ld_shift = bus_resp_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld_msb = 1'b0;
    case (op_q[1:0])
      2'd0:    ld_msb = ld_shift[7];
      2'd1:    ld_msb = ld_shift[15];
      2'd2:    ld_msb = ld_shift[31];
      default: ld_msb = ld_shift[XLEN-1];
    endcase
    ld_ext = '0;
    for (int i = 0; i < XLEN; i++)
      ld_ext[i] = (i < (8 << op_q[1:0])) ? ld_shift[i] : (ld_msb & ~op_q[2]);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    op_d    = op_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wen_d   = in_wen;
          op_d    = in_op;
          lane_d  = in_lane;
          addr_d  = {in_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          wdata_d = in_wen ? st_data : '0;
          wstrb_d = in_wen ? st_strb : '0;
          rdata_d = '0;
          err_d   = in_err;
          state_d = in_err ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_req_ready) state_d = RESP;
      end
      RESP: begin
        if (bus_resp_valid) begin
          rdata_d = wen_q ? '0 : ld_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      op_q    <= 3'd0;
      lane_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // A request presented while reset is asserted must not look accepted.
  assign in_ready      = (state_q == IDLE) && !rst;
  assign bus_req_valid = (state_q == REQ);
  assign out_valid     = (state_q == DONE);
  assign bus_req_wen   = wen_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_wstrb = wstrb_q;
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a 32-bit and a 64-bit instance share one stimulus set;
// sel picks which instance receives handshakes and which one is observed.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0, in_wen = 1'b0;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_addr = 32'd0;
  logic [63:0] in_wdata = 64'd0;
  logic        out_ready = 1'b0, bus_req_ready = 1'b0, bus_resp_valid = 1'b0;
  logic [63:0] bus_resp_rdata = 64'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_in_ready, a_out_valid, a_err, a_bvalid, a_bwen;
  logic [31:0] a_rdata, a_baddr, a_bwdata;
  logic [3:0]  a_bwstrb;
  // 64-bit instance
  logic        b_in_ready, b_out_valid, b_err, b_bvalid, b_bwen;
  logic [63:0] b_rdata, b_bwdata;
  logic [31:0] b_baddr;
  logic [7:0]  b_bwstrb;

  mem_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_wen(in_wen),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
    .out_rdata(a_rdata), .out_err(a_err),
    .bus_req_valid(a_bvalid), .bus_req_ready(bus_req_ready & ~sel),
    .bus_req_wen(a_bwen), .bus_req_addr(a_baddr), .bus_req_wdata(a_bwdata),
    .bus_req_wstrb(a_bwstrb), .bus_resp_valid(bus_resp_valid & ~sel),
    .bus_resp_rdata(bus_resp_rdata[31:0])
  );

  mem_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_wen(in_wen),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(b_out_valid), .out_ready(out_ready & sel),
    .out_rdata(b_rdata), .out_err(b_err),
    .bus_req_valid(b_bvalid), .bus_req_ready(bus_req_ready & sel),
    .bus_req_wen(b_bwen), .bus_req_addr(b_baddr), .bus_req_wdata(b_bwdata),
    .bus_req_wstrb(b_bwstrb), .bus_resp_valid(bus_resp_valid & sel),
    .bus_resp_rdata(bus_resp_rdata)
  );

  logic        o_in_ready, o_out_valid, o_err, o_bvalid, o_bwen;
  logic [63:0] o_rdata, o_bwdata;
  logic [31:0] o_baddr;
  logic [7:0]  o_bwstrb;
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_err       = sel ? b_err       : a_err;
  assign o_bvalid    = sel ? b_bvalid    : a_bvalid;
  assign o_bwen      = sel ? b_bwen      : a_bwen;
  assign o_rdata     = sel ? b_rdata     : {32'd0, a_rdata};
  assign o_bwdata    = sel ? b_bwdata    : {32'd0, a_bwdata};
  assign o_baddr     = sel ? b_baddr     : a_baddr;
  assign o_bwstrb    = sel ? b_bwstrb    : {4'd0, a_bwstrb};

  // Reference model: byte-arithmetic view of one access.
  function automatic void model(input int xlen, input logic wen, input logic [2:0] op,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata_in, output logic err,
                                output logic [31:0] eaddr, output logic [63:0] ewdata,
                                output logic [7:0] estrb, output logic [63:0] erdata);
    int bytes, nb, lane;
    logic [63:0] mask, val, rdata, wmask;
    bytes = 1 << op[1:0];
    nb    = xlen / 8;
    lane  = int'(addr % nb);
    wmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    rdata = rdata_in & wmask;
    mask  = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (bytes * 8)) - 64'd1);
    err   = (op == 3'd7) || (addr % bytes != 0) || (xlen == 32 && (bytes == 8 || op == 3'd6));
    eaddr = addr - lane;
    ewdata = wen ? (((wdata & mask) << (lane * 8)) & wmask) : 64'd0;
    estrb  = wen ? 8'(((1 << bytes) - 1) << lane) : 8'd0;
    val = (rdata >> (lane * 8)) & mask;
    if (op < 3'd4 && bytes < 8 && val[bytes*8-1]) val = val | ~mask;
    erdata = (wen || err) ? 64'd0 : (val & wmask);
  endfunction

  // One complete access: accept, bus request with optional stall and
  // ignored stray responses, response after a delay, result with stall.
  task automatic do_txn(input logic s, input logic w, input logic [2:0] op,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int rstall, input int rspdly, input int ostall, input string tag);
    logic e;
    logic [31:0] ea;
    logic [63:0] ew, er;
    logic [7:0] es;
    model(s ? 64 : 32, w, op, addr, wd, rd, e, ea, ew, es, er);
    sel = s;
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_idle got=%b exp=1", tag, o_in_ready);
    end
    in_valid = 1'b1; in_wen = w; in_op = op; in_addr = addr; in_wdata = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_wen = 1'($urandom); in_op = 3'($urandom);
    in_addr = $urandom; in_wdata = {$urandom, $urandom};
    if (!e) begin
      for (int c = 0; c <= rstall; c++) begin
        checks++;
        if (o_bvalid !== 1'b1 || o_bwen !== w || o_baddr !== ea || o_bwstrb !== es ||
            (w && o_bwdata !== ew)) begin
          errors++;
          $display("FAIL %s bus_req c=%0d got v=%b w=%b a=%h d=%h s=%h exp v=1 w=%b a=%h d=%h s=%h",
                   tag, c, o_bvalid, o_bwen, o_baddr, o_bwdata, o_bwstrb, w, ea, ew, es);
        end
        checks++;
        if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0) begin
          errors++; $display("FAIL %s req_phase got in_ready=%b out_valid=%b exp 0 0",
                             tag, o_in_ready, o_out_valid);
        end
        if (c == rstall) bus_req_ready = 1'b1;
        else begin
          bus_resp_valid = 1'($urandom_range(0, 1));
          bus_resp_rdata = {$urandom, $urandom};
        end
        @(posedge clk); #1;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
      end
      for (int c = 0; c <= rspdly; c++) begin
        checks++;
        if (o_bvalid !== 1'b0 || o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin
          errors++; $display("FAIL %s resp_wait got bvalid=%b out_valid=%b in_ready=%b exp 0 0 0",
                             tag, o_bvalid, o_out_valid, o_in_ready);
        end
        if (c == rspdly) begin bus_resp_valid = 1'b1; bus_resp_rdata = rd; end
        @(posedge clk); #1;
        bus_resp_valid = 1'b0; bus_resp_rdata = {$urandom, $urandom};
      end
    end
    for (int c = 0; c <= ostall; c++) begin
      checks++;
      if (o_out_valid !== 1'b1 || o_err !== e || o_rdata !== er) begin
        errors++;
        $display("FAIL %s result c=%0d got v=%b err=%b rdata=%h exp v=1 err=%b rdata=%h",
                 tag, c, o_out_valid, o_err, o_rdata, e, er);
      end
      checks++;
      if (o_in_ready !== 1'b0 || o_bvalid !== 1'b0) begin
        errors++; $display("FAIL %s done_phase got in_ready=%b bvalid=%b exp 0 0",
                           tag, o_in_ready, o_bvalid);
      end
      if (c == ostall) out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    $display("txn %s sel=%0d wen=%0d op=%0d addr=%h err=%0d rdata=%h", tag, s, w, op, addr, e, er);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset in_ready got=%b%b exp=00", a_in_ready, b_in_ready);
    end
    checks++;
    if ({a_out_valid, a_bvalid, a_err, a_rdata} !== 35'd0 ||
        {b_out_valid, b_bvalid, b_err, b_rdata} !== 67'd0) begin
      errors++; $display("FAIL reset outputs got a=%b%b%b %h b=%b%b%b %h exp all 0",
                         a_out_valid, a_bvalid, a_err, a_rdata, b_out_valid, b_bvalid, b_err, b_rdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release in_ready got=%b%b exp=11", a_in_ready, b_in_ready);
    end
    $display("txn reset done");
  endtask

  task automatic test_directed();
    do_txn(0, 0, 3'd0, 32'h8000_0003, 64'd0, 64'h8011_2233, 0, 0, 0, "lb");
    do_txn(0, 0, 3'd5, 32'h8000_0002, 64'd0, 64'hBEEF_1234, 0, 0, 0, "lhu");
    do_txn(0, 0, 3'd1, 32'h8000_0002, 64'd0, 64'hBEEF_1234, 0, 0, 0, "lh");
    do_txn(0, 1, 3'd1, 32'h8000_0002, 64'h1234_ABCD, 64'd0, 0, 0, 0, "sh");
    do_txn(0, 0, 3'd2, 32'h8000_0001, 64'd0, 64'd0, 0, 0, 0, "lw_mis");
    do_txn(0, 0, 3'd3, 32'h8000_0000, 64'd0, 64'd0, 0, 0, 0, "ld32");
    do_txn(0, 0, 3'd6, 32'h8000_0004, 64'd0, 64'd0, 0, 0, 0, "lwu32");
    do_txn(0, 0, 3'd7, 32'h8000_0000, 64'd0, 64'd0, 0, 0, 0, "op7");
    do_txn(1, 0, 3'd6, 32'h8000_0004, 64'd0, 64'hF000_0000_0000_0000, 0, 0, 0, "lwu64");
    do_txn(1, 0, 3'd3, 32'h8000_0008, 64'd0, 64'h8123_4567_89AB_CDEF, 0, 0, 0, "ld64");
    do_txn(1, 1, 3'd3, 32'h8000_0008, 64'hDEAD_BEEF_0BAD_F00D, 64'd0, 0, 0, 0, "sd64");
    do_txn(1, 1, 3'd0, 32'h8000_0007, 64'h0000_0000_0000_00A5, 64'd0, 0, 0, 0, "sb64");
  endtask

  task automatic test_stall();
    do_txn(0, 0, 3'd2, 32'h8000_0004, 64'd0, 64'hCAFE_F00D, 3, 1, 2, "stall_lw");
    do_txn(0, 1, 3'd0, 32'h8000_0001, 64'h0000_0077, 64'd0, 3, 0, 2, "stall_sb");
  endtask

  task automatic test_ignore_resp();
    sel = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus_resp_valid = 1'b1; bus_resp_rdata = {$urandom, $urandom};
      @(posedge clk); #1;
      bus_resp_valid = 1'b0;
      checks++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
        errors++; $display("FAIL ignore_resp got out_valid=%b in_ready=%b exp 0 1",
                           o_out_valid, o_in_ready);
      end
    end
    $display("txn ignore_resp done");
  endtask

  task automatic test_random();
    logic s, w;
    logic [2:0] op;
    logic [31:0] addr;
    for (int n = 0; n < 300; n++) begin
      s  = 1'($urandom);
      w  = 1'($urandom);
      op = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << op[1:0]) - 32'd1);
      do_txn(s, w, op, addr, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end
  endtask

  // where: 0 = reset in REQ, 1 = in RESP, 2 = in DONE
  task automatic test_reset_mid(input logic s, input int where);
    sel = s;
    in_valid = 1'b1; in_wen = 1'b0; in_op = 3'd2; in_addr = 32'h8000_0004; in_wdata = 64'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (where >= 1) begin bus_req_ready = 1'b1; @(posedge clk); #1; bus_req_ready = 1'b0; end
    if (where >= 2) begin
      bus_resp_valid = 1'b1; bus_resp_rdata = 64'h1234_5678_9ABC_DEF0;
      @(posedge clk); #1;
      bus_resp_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (o_in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid%0d in_ready_during got=%b exp=0", where, o_in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (o_out_valid !== 1'b0 || o_bvalid !== 1'b0 || o_err !== 1'b0 || o_rdata !== 64'd0 ||
        o_in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid%0d after got v=%b bv=%b err=%b rdata=%h rdy=%b exp 0 0 0 0 1",
                         where, o_out_valid, o_bvalid, o_err, o_rdata, o_in_ready);
    end
    bus_resp_valid = 1'b1; bus_resp_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    bus_resp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) begin
        errors++; $display("FAIL rst_mid%0d late_resp got out_valid=%b in_ready=%b exp 0 1",
                           where, o_out_valid, o_in_ready);
      end
      @(posedge clk); #1;
    end
    $display("txn reset_mid where=%0d sel=%0d done", where, s);
    do_txn(s, 0, 3'd1, 32'h8000_0006, 64'd0, 64'h8765_4321_FEDC_BA98, 0, 0, 0, "post_rst");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_ignore_resp();
    test_random();
    test_reset_mid(1'b1, 1);
    test_reset_mid(1'b0, 0);
    test_reset_mid(1'b1, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
